// File: rtl/core_muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// core_muldiv_seq_pkg
//   Shared types and constants for the iterative multiply/divide sequencer.
//   muldiv_op_t    : {is_div, is_signed, is_word, rsvd} as driven by ID
//   muldiv_state_t : IDLE / RUN / FIX
//   muldiv_clz     : leading-zero count of a 64-bit value (64 when zero),
//                    used by the divide pre-shift when early-out is built in.
// -----------------------------------------------------------------------------
package core_muldiv_seq_pkg;

    localparam int MULDIV_WORD_ITERS  = 32;
    localparam int MULDIV_DWORD_ITERS = 64;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic is_word;
        logic rsvd;
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic [6:0] muldiv_clz(input logic [63:0] v);
        logic [6:0] n;
        logic       found;
        n     = 7'd64;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 7'(63 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/core_muldiv_seq_au.sv
// -----------------------------------------------------------------------------
// au
//   Add/subtract unit shared by the multiply (add) and divide (subtract) step.
//   Ports:
//     x_i    in  W   first operand
//     y_i    in  W   second operand
//     sub_i  in  1   1: x - y, 0: x + y
//     res_o  out W   result
//     cout_o out 1   carry out; for subtract, 1 means no borrow (x >= y)
// -----------------------------------------------------------------------------
module au #(
    parameter int W = 65
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         sub_i,
    output logic [W-1:0] res_o,
    output logic         cout_o
);

    assign {cout_o, res_o} = {1'b0, x_i} + {1'b0, y_i ^ {W{sub_i}}} + {{W{1'b0}}, sub_i};

endmodule

// File: rtl/core_muldiv_seq.sv
// -----------------------------------------------------------------------------
// core_muldiv_seq
//   Iterative multiply/divide sequencer owning HI/LO. One bit per cycle:
//   shift-add multiply or restoring divide on operand magnitudes, with sign
//   fix-up in a final cycle. Raises stall_req while a dependent instruction
//   in ID must wait on the unit.
//
//   Optional build macro CORE_MULDIV_EARLY_OUT_EN: multiply leaves RUN once the
//   remaining multiplier bits are zero, divide pre-shifts the dividend past its
//   leading zeros on entry. Results are unchanged, only latency shrinks.
//
//   Ports:
//     clock, reset   clock, async active-high reset
//     flush          abort in-flight op / ignore start this cycle
//     start, op      MULT/DIV-class instruction in ID and its decode
//     a, b           forwarded rs / rt operands
//     hilo_rd        MFHI/MFLO in ID
//     hi_we, lo_we   MTHI/MTLO writes (data from a)
//     busy           op in flight
//     stall_req      hold ID while busy and ID needs the unit
//     done           one-cycle pulse as HI/LO take an op result
//     hi, lo         HI/LO registers
//
//   state | meaning
//   IDLE  | waiting; accepts start or MTHI/MTLO
//   RUN   | one multiply/divide iteration per cycle
//   FIX   | sign correction, HI/LO write, done pulse
// -----------------------------------------------------------------------------
module core_muldiv_seq
    import core_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            start,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hilo_rd,
    input  logic            hi_we,
    input  logic            lo_we,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = 7;

    muldiv_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] acc_q;      // mul: product high half / div: remainder
    logic [XLEN-1:0] mq_q;       // mul: multiplier+product low / div: dividend+quotient
    logic [XLEN-1:0] opnd_q;     // mul: multiplicand / div: divisor
    logic [XLEN-1:0] hi_q, lo_q;
    logic            div_q, word_q, div0_q, neg_res_q, neg_rem_q, done_q;

    logic accept, fix_wr, run_last;
    logic op_rsvd_unused;

    assign op_rsvd_unused = op.rsvd;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // ---------------- operand capture ----------------
    logic            a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_mag, b_mag, dvd_field, dvd_init;
    logic [CW-1:0]   iters, div_cnt_init;

    always_comb begin
        a_neg  = op.is_signed & (op.is_word ? a[31] : a[XLEN-1]);
        b_neg  = op.is_signed & (op.is_word ? b[31] : b[XLEN-1]);
        b_zero = op.is_word ? (b[31:0] == 32'd0) : (b == '0);
        iters  = op.is_word ? CW'(MULDIV_WORD_ITERS) : CW'(MULDIV_DWORD_ITERS);

        a_mag = a;
        b_mag = b;
        if (op.is_word) begin
            a_mag = {{(XLEN-32){1'b0}}, a[31:0]};
            b_mag = {{(XLEN-32){1'b0}}, b[31:0]};
            if (a_neg) a_mag[31:0] = -a[31:0];
            if (b_neg) b_mag[31:0] = -b[31:0];
        end else begin
            if (a_neg) a_mag = -a;
            if (b_neg) b_mag = -b;
        end

        // word dividends sit in the top half so quotient bits emerge in [31:0]
        dvd_field = op.is_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
    end

`ifdef CORE_MULDIV_EARLY_OUT_EN
    logic [CW-1:0] lz;
    always_comb begin
        lz = muldiv_clz(dvd_field);
        // keep at least one iteration so a zero dividend still walks RUN once
        if (lz > iters - CW'(1)) lz = iters - CW'(1);
        dvd_init     = dvd_field << lz;
        div_cnt_init = iters - lz;
    end
`else
    assign dvd_init     = dvd_field;
    assign div_cnt_init = iters;
`endif

    // ---------------- iteration step ----------------
    logic [XLEN:0]   au_x, au_y, au_res;
    logic            au_cout;
    logic [XLEN-1:0] acc_step, mq_step;

    always_comb begin
        if (div_q) begin
            au_x = {acc_q, mq_q[XLEN-1]};
            au_y = {1'b0, opnd_q};
        end else begin
            au_x = {1'b0, acc_q};
            au_y = mq_q[0] ? {1'b0, opnd_q} : '0;
        end
    end

    au #(.W(XLEN + 1)) u_au (
        .x_i    (au_x),
        .y_i    (au_y),
        .sub_i  (div_q),
        .res_o  (au_res),
        .cout_o (au_cout)
    );

    always_comb begin
        if (div_q) begin
            // borrow means shifted remainder < divisor: restore by keeping it
            if (au_cout) begin
                acc_step = au_res[XLEN-1:0];
                mq_step  = {mq_q[XLEN-2:0], 1'b1};
            end else begin
                acc_step = au_x[XLEN-1:0];
                mq_step  = {mq_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = au_res[XLEN:1];
            mq_step  = {au_res[0], mq_q[XLEN-1:1]};
        end
    end

`ifdef CORE_MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] mpl_mask;
    always_comb begin
        // bits of the multiplier still to be consumed after this iteration
        mpl_mask = ({{(XLEN-1){1'b0}}, 1'b1} << (cnt_q - CW'(1))) - {{(XLEN-1){1'b0}}, 1'b1};
        run_last = (cnt_q == CW'(1)) | (~div_q & (((mq_q >> 1) & mpl_mask) == '0));
    end
`else
    assign run_last = (cnt_q == CW'(1));
`endif

    // ---------------- result fix-up ----------------
    logic [2*XLEN-1:0] prod, prod_n;
    logic [63:0]       prod_w;
    logic [XLEN-1:0]   quo_n, rem_n, hi_res, lo_res;

    always_comb begin
`ifdef CORE_MULDIV_EARLY_OUT_EN
        // an early exit leaves the product short of its final alignment
        prod = {acc_q, mq_q} >> cnt_q;
`else
        prod = {acc_q, mq_q};
`endif
        prod_n = neg_res_q ? -prod : prod;
        // after 32 word iterations the product sits at bit XLEN-32
        prod_w = prod_n[XLEN+31:XLEN-32];
        quo_n  = neg_res_q ? -mq_q : mq_q;
        rem_n  = neg_rem_q ? -acc_q : acc_q;

        if (div0_q) begin
            lo_res = '1;
            hi_res = word_q ? sext32(acc_q[31:0]) : acc_q;
        end else if (div_q) begin
            lo_res = word_q ? sext32(quo_n[31:0]) : quo_n;
            hi_res = word_q ? sext32(rem_n[31:0]) : rem_n;
        end else if (word_q) begin
            lo_res = sext32(prod_w[31:0]);
            hi_res = sext32(prod_w[63:32]);
        end else begin
            lo_res = prod_n[XLEN-1:0];
            hi_res = prod_n[2*XLEN-1:XLEN];
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !flush) state_d = (op.is_div && b_zero) ? FIX : RUN;
            RUN: begin
                if (flush)         state_d = IDLE;
                else if (run_last) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        stall_req = busy & (start | hilo_rd | hi_we | lo_we);
        accept    = (state_q == IDLE) & start & ~flush;
        fix_wr    = (state_q == FIX) & ~flush;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            word_q    <= 1'b0;
            div0_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= fix_wr;
            if (accept) begin
                div_q     <= op.is_div;
                word_q    <= op.is_word;
                div0_q    <= op.is_div & b_zero;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                if (op.is_div && b_zero) begin
                    acc_q  <= a;          // raw dividend becomes HI
                    mq_q   <= '0;
                    opnd_q <= '0;
                    cnt_q  <= '0;
                end else if (op.is_div) begin
                    acc_q  <= '0;
                    mq_q   <= dvd_init;
                    opnd_q <= b_mag;
                    cnt_q  <= div_cnt_init;
                end else begin
                    acc_q  <= '0;
                    mq_q   <= b_mag;
                    opnd_q <= a_mag;
                    cnt_q  <= iters;
                end
            end else if (state_q == IDLE && !flush) begin
                // a squashed MTHI/MTLO must not land either
                if (hi_we) hi_q <= a;
                if (lo_we) lo_q <= a;
            end else if (state_q == RUN && !flush) begin
                acc_q <= acc_step;
                mq_q  <= mq_step;
                cnt_q <= cnt_q - CW'(1);
            end

            if (fix_wr) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
